data_mem_responder: RTL and testbench

//   Word-addressed data memory acting as the responder side of the CPU load/store port.

---
 rtl/data_mem_responder.sv | 189 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers CPU load/store requests after a
// fixed number of wait states, with valid/ready handshakes on both sides.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [3:0]     cnt_r;
  logic [3:0]     cnt_nxt_s;

  logic           lat_write_r;
  logic [31:0]    lat_addr_r;
  logic [31:0]    lat_wdata_r;

  logic           req_ready_r;
  logic           resp_valid_r;
  logic           resp_err_r;
  logic [31:0]    resp_rdata_r;

  logic           req_ready_nxt_s;
  logic           resp_valid_nxt_s;
  logic           resp_err_nxt_s;
  logic [31:0]    resp_rdata_nxt_s;

  logic           accept_s;
  logic           commit_s;
  logic           cmd_write_s;
  logic           cmd_err_s;
  logic [31:0]    cmd_addr_s;
  logic [31:0]    cmd_wdata_s;
  logic [31:0]    off_s;
  logic [AW-1:0]  idx_s;

  logic [31:0]    mem_r [DEPTH_WORDS];

  assign accept_s = req_valid && req_ready_r && (state_r == ST_IDLE);

  // Command source and address decode: live inputs when committing straight from IDLE
  always_comb begin
    if (state_r == ST_IDLE) begin
      cmd_write_s = req_write;
      cmd_addr_s  = req_addr;
      cmd_wdata_s = req_wdata;
    end else begin
      cmd_write_s = lat_write_r;
      cmd_addr_s  = lat_addr_r;
      cmd_wdata_s = lat_wdata_r;
    end
    off_s     = cmd_addr_s - BASE_ADDR;
    cmd_err_s = (cmd_addr_s[1:0] != 2'b00) || (off_s >= LIMIT);
    idx_s     = off_s[AW+1:2];
  end

  // Next-state and wait counter logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = 4'd0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (WS == 4'd0) begin
            state_nxt_s = ST_RESP;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = 4'd1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == WS) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = cnt_r + 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign commit_s = (state_r != ST_RESP) && (state_nxt_s == ST_RESP);

  // Next values of the registered outputs; response fields captured at commit
  always_comb begin
    req_ready_nxt_s  = (state_nxt_s == ST_IDLE);
    resp_valid_nxt_s = (state_nxt_s == ST_RESP);
    resp_err_nxt_s   = 1'b0;
    resp_rdata_nxt_s = 32'h0000_0000;
    if (commit_s) begin
      resp_err_nxt_s = cmd_err_s;
      if (cmd_write_s || cmd_err_s) begin
        resp_rdata_nxt_s = 32'h0000_0000;
      end else begin
        resp_rdata_nxt_s = mem_r[idx_s];
      end
    end else if (state_nxt_s == ST_RESP) begin
      resp_err_nxt_s   = resp_err_r;
      resp_rdata_nxt_s = resp_rdata_r;
    end else begin
      resp_err_nxt_s   = 1'b0;
      resp_rdata_nxt_s = 32'h0000_0000;
    end
  end

  // State, counter and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      req_ready_r  <= req_ready_nxt_s;
      resp_valid_r <= resp_valid_nxt_s;
      resp_err_r   <= resp_err_nxt_s;
      resp_rdata_r <= resp_rdata_nxt_s;
    end
  end

  // Request capture on the accept edge
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_write_r <= 1'b0;
      lat_addr_r  <= 32'h0000_0000;
      lat_wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      lat_write_r <= req_write;
      lat_addr_r  <= req_addr;
      lat_wdata_r <= req_wdata;
    end else begin
      lat_write_r <= lat_write_r;
      lat_addr_r  <= lat_addr_r;
      lat_wdata_r <= lat_wdata_r;
    end
  end

  // Storage array; contents survive reset, a write lands only at commit
  always_ff @(posedge clock) begin
    if (!reset && commit_s && cmd_write_s && !cmd_err_s) begin
      mem_r[idx_s] <= cmd_wdata_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_STATES=2 instance and a
// WAIT_STATES=0 instance sharing clock, reset and request/response buses.
module tb_data_mem_responder;

  logic        clock;
  logic        reset;
  logic        req_valid_a, req_valid_b;
  logic        req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_ready;
  logic        rdy_a, rdy_b, vld_a, vld_b, err_a, err_b;
  logic [31:0] rdata_a, rdata_b;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .BASE_ADDR(32'h0000_0000)) u_dut_a (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_a), .req_ready(rdy_a), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld_a), .resp_ready(resp_ready), .resp_rdata(rdata_a), .resp_err(err_a)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) u_dut_b (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_b), .req_ready(rdy_b), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld_b), .resp_ready(resp_ready), .resp_rdata(rdata_b), .resp_err(err_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, then scramble inputs; returns response fields and latency
  task automatic do_req(input bit sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdo,
                        output logic ero, output int lato);
    int n;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    n = 0;
    while (!(sel ? rdy_b : rdy_a) && n < 20) begin
      tick;
      n++;
    end
    if (n >= 20) check("accept_timeout", 32'd0, 32'd1);
    tick;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    req_write   = ~wr;
    req_addr    = 32'hFFFF_FFF0;
    req_wdata   = 32'h0BAD_0BAD;
    lato = 1;
    while (!(sel ? vld_b : vld_a) && lato < 20) begin
      tick;
      lato++;
    end
    rdo = sel ? rdata_b : rdata_a;
    ero = sel ? err_b : err_a;
  endtask

  task automatic consume;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    req_valid_a = 1'b1;
    req_valid_b = 1'b1;
    req_write   = 1'b0;
    req_addr    = 32'h0000_0000;
    req_wdata   = 32'h0000_0000;
    resp_ready  = 1'b0;

    // Reset held two cycles with a request pending
    tick;
    check("rst1_ready", {31'd0, rdy_a}, 32'd0);
    check("rst1_valid", {31'd0, vld_a}, 32'd0);
    tick;
    check("rst2_ready", {31'd0, rdy_a}, 32'd0);
    check("rst2_valid", {31'd0, vld_a}, 32'd0);
    reset       = 1'b0;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    tick;
    check("post_rst_ready", {31'd0, rdy_a}, 32'd1);
    check("post_rst_valid", {31'd0, vld_a}, 32'd0);

    // Store then load, 2 wait states
    do_req(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, er, lat);
    check("sw_lat", 32'(lat), 32'd3);
    check("sw_rdata", rd, 32'h0000_0000);
    check("sw_err", {31'd0, er}, 32'd0);
    consume;
    do_req(1'b0, 1'b0, 32'h0000_0010, 32'h0, rd, er, lat);
    check("lw_lat", 32'(lat), 32'd3);
    check("lw_rdata", rd, 32'hDEAD_BEEF);
    check("lw_err", {31'd0, er}, 32'd0);

    // Backpressure: response held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp_valid", {31'd0, vld_a}, 32'd1);
      check("bp_rdata", rdata_a, 32'hDEAD_BEEF);
      check("bp_ready", {31'd0, rdy_a}, 32'd0);
    end
    consume;
    check("bp_release_valid", {31'd0, vld_a}, 32'd0);
    check("bp_release_ready", {31'd0, rdy_a}, 32'd1);

    // Error cases
    do_req(1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, rd, er, lat);
    consume;
    do_req(1'b0, 1'b0, 32'h0000_0006, 32'h0, rd, er, lat);
    check("mis_lat", 32'(lat), 32'd3);
    check("mis_err", {31'd0, er}, 32'd1);
    check("mis_rdata", rd, 32'h0000_0000);
    consume;
    do_req(1'b0, 1'b1, 32'h0000_0400, 32'h5555_5555, rd, er, lat);
    check("oor_lat", 32'(lat), 32'd3);
    check("oor_err", {31'd0, er}, 32'd1);
    consume;
    do_req(1'b0, 1'b0, 32'h0000_0000, 32'h0, rd, er, lat);
    check("word0_rdata", rd, 32'hCAFE_F00D);
    check("word0_err", {31'd0, er}, 32'd0);
    consume;

    // Reset in the second wait cycle drops the store
    do_req(1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, rd, er, lat);
    consume;
    req_write   = 1'b1;
    req_addr    = 32'h0000_0020;
    req_wdata   = 32'h1234_5678;
    req_valid_a = 1'b1;
    tick;
    req_valid_a = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    check("midrst_valid", {31'd0, vld_a}, 32'd0);
    check("midrst_ready", {31'd0, rdy_a}, 32'd0);
    reset = 1'b0;
    tick;
    check("midrst_after_ready", {31'd0, rdy_a}, 32'd1);
    check("midrst_after_valid", {31'd0, vld_a}, 32'd0);
    do_req(1'b0, 1'b0, 32'h0000_0020, 32'h0, rd, er, lat);
    check("midrst_old_rdata", rd, 32'hA5A5_A5A5);
    consume;

    // Zero wait states
    do_req(1'b1, 1'b1, 32'h0000_0010, 32'h1111_0000, rd, er, lat);
    check("ws0_sw_lat", 32'(lat), 32'd1);
    consume;
    do_req(1'b1, 1'b1, 32'h0000_0014, 32'h2222_0000, rd, er, lat);
    consume;
    resp_ready  = 1'b1;
    req_write   = 1'b0;
    req_addr    = 32'h0000_0010;
    req_valid_b = 1'b1;
    tick;
    check("b2b_valid1", {31'd0, vld_b}, 32'd1);
    check("b2b_rdata1", rdata_b, 32'h1111_0000);
    check("b2b_ready1", {31'd0, rdy_b}, 32'd0);
    req_addr = 32'h0000_0014;
    tick;
    check("b2b_gap_valid", {31'd0, vld_b}, 32'd0);
    check("b2b_gap_ready", {31'd0, rdy_b}, 32'd1);
    tick;
    check("b2b_valid2", {31'd0, vld_b}, 32'd1);
    check("b2b_rdata2", rdata_b, 32'h2222_0000);
    req_valid_b = 1'b0;
    tick;
    resp_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
